// File: rtl/sync_pkg.sv
// Shared definitions for the fast-to-slow hold-the-signal synchronizer.
//   state_t          : handshake FSM state, 2-bit encoding
//   SYNC_STAGES_MIN  : shortest supported synchronizer chain
//   SYNC_STAGES_MAX  : longest supported synchronizer chain
package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous active-high reset.
// Also usable for the ack path on the fast side.
//   i_clk : destination clock
//   i_rst : synchronous reset, active-high, clears the whole chain
//   i_d   : asynchronous input bit, goes straight into the first flop
//   o_q   : synchronized bit, STAGES destination edges later
module sync_bit
  import sync_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_MIN
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // i_d feeds r_sync[0] directly: any gate in front of the first flop
  // could glitch on the asynchronous input and be captured.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/sync_f2s_s.sv
// Slow-domain end of the fast-to-slow hold-the-signal handshake.
// Synchronizes the level-held request, emits one rd_en_o pulse per
// request and returns a four-phase acknowledge to the fast side.
//   clk_s       : slow-domain clock
//   rst         : synchronous reset, active-high
//   rd_en_i     : held request from the fast domain (asynchronous)
//   rd_en_o     : one-cycle read enable, one per accepted request
//   rd_en_ack_o : registered acknowledge back to the fast domain
//   busy_o      : handshake in progress (state != IDLE)
//   req_cnt_o   : accepted-request count, wraps modulo 2^CNT_W
module sync_f2s_s
  import sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_MIN_CYC = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk_s,
  input  logic             rst,
  input  logic             rd_en_i,
  output logic             rd_en_o,
  output logic             rd_en_ack_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] req_cnt_o
);

  // Out-of-range chain lengths are clamped into the supported range.
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                          (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                          SYNC_STAGES;
  localparam int HOLD_W = (ACK_MIN_CYC > 1) ? $clog2(ACK_MIN_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(ACK_MIN_CYC - 1);

  logic              w_req_s;
  state_t            r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_pulse, w_pulse_nxt;
  logic              r_ack, w_ack_nxt;

  sync_bit #(.STAGES(SYNC_N)) u_sync (
    .i_clk (clk_s),
    .i_rst (rst),
    .i_d   (rd_en_i),
    .o_q   (w_req_s)
  );

  // State register; outputs are registered here too so the ack seen by
  // the fast domain is a clean flop output.
  always_ff @(posedge clk_s) begin
    if (rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Next state. Once accepted, the request is not looked at again until
  // WAIT_LOW, so a long hold can only ever yield one pulse.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_req_s)       w_state_nxt = HOLD;
      HOLD:     if (r_hold == '0)  w_state_nxt = WAIT_LOW;
      WAIT_LOW: if (!w_req_s)      w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and the hold counter.
  always_comb begin
    w_pulse_nxt = (r_state == IDLE) && w_req_s;
    w_ack_nxt   = (w_state_nxt != IDLE);
    w_cnt_nxt   = r_cnt + CNT_W'(w_pulse_nxt);
    w_hold_nxt  = r_hold;
    if (w_pulse_nxt)
      w_hold_nxt = HOLD_INIT;
    else if (r_state == HOLD && r_hold != '0)
      w_hold_nxt = r_hold - HOLD_W'(1);
  end

  assign rd_en_o     = r_pulse;
  assign rd_en_ack_o = r_ack;
  assign busy_o      = (r_state != IDLE);
  assign req_cnt_o   = r_cnt;

endmodule
